branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter COUNT_W, default 16, width of the taken-branch counter.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ex_valid  input  1  execute-stage instruction valid.
REQ-005 stall  input  1  execute stage held; qualifies ex_valid.
REQ-006 branch_ex  input  1  conditional branch in execute.
REQ-007 jump_ex  input  1  unconditional jump (jal/jalr) in execute.
REQ-008 funct3_ex  input  3  branch condition select.
REQ-009 zero, negative, carry, overflow  input  1 each  ALU flags from A-B subtraction.
REQ-010 pc_target_ex  input  32  computed branch/jump target.
REQ-011 pc_src  output  1  registered; selects pc_target at fetch.
REQ-012 pc_target  output  32  registered redirect address.
REQ-013 flush_d  output  1  registered; clear decode-stage register.
REQ-014 flush_e  output  1  registered; clear execute-stage register.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 taken_count  output  COUNT_W  saturating count of resolved redirects.

Function
REQ-017 Accept condition: ex_valid=1, stall=0, state=IDLE; inputs SHALL be ignored otherwise.
REQ-018 Condition decode from flags: eq=zero; lt=negative^overflow; ltu=~carry.
REQ-019 funct3 000 taken=eq; 001 taken=~eq; 100 taken=lt; 101 taken=~lt; 110 taken=ltu; 111 taken=~ltu; 010/011 taken=0.
REQ-020 redirect = accepted & (jump_ex | (branch_ex & taken)); jump_ex SHALL override branch_ex and funct3.
REQ-021 States: IDLE, REDIRECT, RECOVER, encoded as 2-bit register.
REQ-022 IDLE -> REDIRECT on redirect; otherwise remain IDLE.
REQ-023 REDIRECT -> RECOVER unconditionally after one cycle; RECOVER -> IDLE unconditionally after one cycle.
REQ-024 Stall SHALL NOT extend REDIRECT or RECOVER; the sequence is always exactly 2 cycles.
REQ-025 In REDIRECT: pc_src=1, flush_d=1, flush_e=1, pc_target holds value captured at acceptance.
REQ-026 In RECOVER: pc_src=0, flush_d=0, flush_e=1 (squash wrong-path instruction already in decode).
REQ-027 In IDLE: pc_src=0, flush_d=0, flush_e=0; pc_target holds last captured value.
REQ-028 pc_target SHALL load pc_target_ex only on the edge where IDLE->REDIRECT is taken.
REQ-029 Latency: redirect outputs appear on the first rising edge after the accepted cycle (1 cycle).
REQ-030 taken_count SHALL increment by 1 on each IDLE->REDIRECT transition; saturates at 2^COUNT_W-1, no wrap.
REQ-031 Not-taken branch or non-branch instruction: no state change, no output change, no count change.
REQ-032 Back-to-back redirect requests: a request arriving while in REDIRECT or RECOVER is dropped (it is the wrong path); the first request accepted in IDLE after RECOVER is honoured.
REQ-033 busy SHALL be combinationally derived from state (state != IDLE).

Reset
REQ-034 On rst=1, state=IDLE, pc_src=0, flush_d=0, flush_e=0, pc_target=32'h0, taken_count=0, immediately and independent of clk.
REQ-035 Reset asserted during REDIRECT or RECOVER SHALL abort the sequence; first post-reset cycle is IDLE with all flush outputs 0.
REQ-036 Reset deassertion SHALL take effect synchronously to clk with no spurious redirect.

Verification
REQ-037 beq, zero=1, pc_target_ex=32'h0000_0040, ex_valid=1, stall=0 -> next cycle pc_src=1, flush_d=1, flush_e=1, pc_target=0x40; following cycle flush_e=1 only; then IDLE, taken_count=1.
REQ-038 blt with negative=0, overflow=1 -> taken; bltu with carry=1 -> not taken, all outputs stay 0, count unchanged.
REQ-039 jump_ex=1, branch_ex=0, funct3=010 -> redirect; same with stall=1 -> no redirect.
REQ-040 Redirect request every cycle for 6 cycles -> redirects accepted on cycles 0 and 3 only; taken_count=2.
REQ-041 COUNT_W=2, 5 spaced redirects -> taken_count reaches 3 and holds.
REQ-042 rst pulsed mid-REDIRECT -> outputs 0 asynchronously, pc_target=0, count=0, IDLE next cycle.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolution: decodes the branch condition from ALU
// flags, issues a one-cycle fetch redirect and a two-cycle flush sequence.
module branch_resolve_unit #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               stall,
  input  logic               branch_ex,
  input  logic               jump_ex,
  input  logic [2:0]         funct3_ex,
  input  logic               zero,
  input  logic               negative,
  input  logic               carry,
  input  logic               overflow,
  input  logic [31:0]        pc_target_ex,
  output logic               pc_src,
  output logic [31:0]        pc_target,
  output logic               flush_d,
  output logic               flush_e,
  output logic               busy,
  output logic [COUNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    REDIRECT = 2'b01,
    RECOVER  = 2'b10
  } state_t;

  state_t state_reg, state_next;

  logic               pc_src_reg, pc_src_next;
  logic               flush_d_reg, flush_d_next;
  logic               flush_e_reg, flush_e_next;
  logic [31:0]        pc_target_reg;
  logic [COUNT_W-1:0] count_reg;

  logic       cond_eq, cond_lt, cond_ltu;
  logic [7:0] cond_table;
  logic       taken;
  logic       accept;
  logic       redirect;
  logic       load_target;
  logic       count_sat;

  // Flags come from A-B: carry set means no borrow, i.e. A >= B unsigned.
  assign cond_eq  = zero;
  assign cond_lt  = negative ^ overflow;
  assign cond_ltu = ~carry;

  // Indexed by funct3; encodings 010/011 are not branches and never take.
  assign cond_table = {~cond_ltu, cond_ltu, ~cond_lt, cond_lt,
                       1'b0, 1'b0, ~cond_eq, cond_eq};
  assign taken      = cond_table[funct3_ex];

  assign accept   = ex_valid & ~stall & (state_reg == IDLE);
  assign redirect = accept & (jump_ex | (branch_ex & taken));

  always_comb begin
    state_next   = state_reg;
    load_target  = 1'b0;
    pc_src_next  = 1'b0;
    flush_d_next = 1'b0;
    flush_e_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (redirect) begin
          state_next  = REDIRECT;
          load_target = 1'b1;
        end
      end
      REDIRECT: state_next = RECOVER;
      RECOVER:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    case (state_next)
      REDIRECT: begin
        pc_src_next  = 1'b1;
        flush_d_next = 1'b1;
        flush_e_next = 1'b1;
      end
      RECOVER: flush_e_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      pc_src_reg  <= 1'b0;
      flush_d_reg <= 1'b0;
      flush_e_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_src_reg  <= pc_src_next;
      flush_d_reg <= flush_d_next;
      flush_e_reg <= flush_e_next;
    end
  end

  assign count_sat = &count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_target_reg <= 32'h0;
      count_reg     <= '0;
    end else if (load_target) begin
      pc_target_reg <= pc_target_ex;
      if (!count_sat) begin
        count_reg <= count_reg + COUNT_W'(1);
      end
    end
  end

  assign pc_src      = pc_src_reg;
  assign flush_d     = flush_d_reg;
  assign flush_e     = flush_e_reg;
  assign pc_target   = pc_target_reg;
  assign taken_count = count_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic
// checked every cycle against a cycle-age reference model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        stall = 1'b0;
  logic        branch_ex = 1'b0;
  logic        jump_ex = 1'b0;
  logic [2:0]  funct3_ex = 3'd0;
  logic        zero = 1'b0;
  logic        negative = 1'b0;
  logic        carry = 1'b0;
  logic        overflow = 1'b0;
  logic [31:0] pc_target_ex = 32'h0;

  logic        pc_src, flush_d, flush_e, busy;
  logic [31:0] pc_target;
  logic [15:0] taken_count;

  logic        s_pc_src, s_flush_d, s_flush_e, s_busy;
  logic [31:0] s_pc_target;
  logic [1:0]  s_taken_count;

  // Operands behind the current flags; the model decides "taken" from these.
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
    .branch_ex(branch_ex), .jump_ex(jump_ex), .funct3_ex(funct3_ex),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .pc_target_ex(pc_target_ex), .pc_src(pc_src), .pc_target(pc_target),
    .flush_d(flush_d), .flush_e(flush_e), .busy(busy), .taken_count(taken_count)
  );

  branch_resolve_unit #(.COUNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall(stall),
    .branch_ex(branch_ex), .jump_ex(jump_ex), .funct3_ex(funct3_ex),
    .zero(zero), .negative(negative), .carry(carry), .overflow(overflow),
    .pc_target_ex(pc_target_ex), .pc_src(s_pc_src), .pc_target(s_pc_target),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .busy(s_busy), .taken_count(s_taken_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return !($signed(a) < $signed(b));
      3'b110:  return a < b;
      3'b111:  return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  // Reference: a redirect is accepted only if at least 3 edges have elapsed
  // since the previous one; outputs follow from the age of the last accept.
  int          cyc = 0;
  int          last_acc = -10;
  logic [31:0] m_target = 32'h0;
  int          m_count = 0;
  int          m_small = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc      <= 0;
      last_acc <= -10;
      m_target <= 32'h0;
      m_count  <= 0;
      m_small  <= 0;
    end else begin
      cyc <= cyc + 1;
      if (ex_valid && !stall && (cyc + 1 - last_acc >= 3) &&
          (jump_ex || (branch_ex && model_taken(funct3_ex, op_a, op_b)))) begin
        last_acc <= cyc + 1;
        m_target <= pc_target_ex;
        m_count  <= (m_count == 65535) ? m_count : m_count + 1;
        m_small  <= (m_small == 3) ? m_small : m_small + 1;
      end
    end
  end

  int age;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      age = cyc - last_acc;
      check("pc_src",      {31'b0, pc_src},       {31'b0, age == 0});
      check("flush_d",     {31'b0, flush_d},      {31'b0, age == 0});
      check("flush_e",     {31'b0, flush_e},      {31'b0, age == 0 || age == 1});
      check("busy",        {31'b0, busy},         {31'b0, age == 0 || age == 1});
      check("pc_target",   pc_target,             m_target);
      check("taken_count", {16'b0, taken_count},  m_count);
      check("small_count", {30'b0, s_taken_count}, m_small);
    end
  end

  task automatic step(input logic v, input logic s, input logic br, input logic j,
                      input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] tgt);
    logic [32:0] d;
    d = {1'b0, a} + {1'b0, ~b} + 33'd1;
    op_a = a;
    op_b = b;
    ex_valid = v;
    stall = s;
    branch_ex = br;
    jump_ex = j;
    funct3_ex = f3;
    zero = (d[31:0] == 32'h0);
    negative = d[31];
    carry = d[32];
    overflow = (a[31] != b[31]) && (d[31] != a[31]);
    pc_target_ex = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h1, 32'hDEAD_BEEF);
  endtask

  initial begin
    // Reset state while rst held.
    #3;
    check("rst_pc_src", {31'b0, pc_src}, 32'd0);
    check("rst_flush_e", {31'b0, flush_e}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_target", pc_target, 32'h0);
    #4 rst = 1'b0;
    chk_en = 1'b1;

    // beq taken.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h1234, 32'h1234, 32'h0000_0040);
    check("beq_pc_src", {31'b0, pc_src}, 32'd1);
    check("beq_flush_d", {31'b0, flush_d}, 32'd1);
    check("beq_flush_e", {31'b0, flush_e}, 32'd1);
    check("beq_target", pc_target, 32'h40);
    idle();
    check("beq_rec_flush_e", {31'b0, flush_e}, 32'd1);
    check("beq_rec_flush_d", {31'b0, flush_d}, 32'd0);
    check("beq_rec_pc_src", {31'b0, pc_src}, 32'd0);
    idle();
    check("beq_idle_busy", {31'b0, busy}, 32'd0);
    check("beq_count", {16'b0, taken_count}, 32'd1);

    // blt: negative=0, overflow=1 -> taken.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b100, 32'h8000_0000, 32'h0000_0001, 32'h0000_0100);
    check("blt_flags", {30'b0, negative, overflow}, 32'd1);
    check("blt_pc_src", {31'b0, pc_src}, 32'd1);
    idle();
    idle();
    // bltu: carry=1 -> not taken, nothing changes.
    step(1'b1, 1'b0, 1'b1, 1'b0, 3'b110, 32'h5, 32'h3, 32'h0000_0200);
    check("bltu_carry", {31'b0, carry}, 32'd1);
    check("bltu_pc_src", {31'b0, pc_src}, 32'd0);
    check("bltu_busy", {31'b0, busy}, 32'd0);
    check("bltu_target", pc_target, 32'h100);
    check("bltu_count", {16'b0, taken_count}, 32'd2);

    // Jump overrides funct3 010; stalled jump is ignored.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0000_0300);
    check("jmp_pc_src", {31'b0, pc_src}, 32'd1);
    idle();
    idle();
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0000_0400);
    check("jmp_stall_pc_src", {31'b0, pc_src}, 32'd0);
    check("jmp_stall_target", pc_target, 32'h300);

    // Back-to-back requests: only cycles 0 and 3 accepted.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h1000 + 32'(i));
      check("b2b_pc_src", {31'b0, pc_src}, {31'b0, (i % 3) == 0});
    end
    check("b2b_target", pc_target, 32'h1003);
    check("b2b_count", {16'b0, taken_count}, 32'd5);
    check("sat_small_count", {30'b0, s_taken_count}, 32'd3);
    idle();
    idle();

    // Async reset mid-REDIRECT.
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0000_0500);
    check("pre_rst_pc_src", {31'b0, pc_src}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_pc_src", {31'b0, pc_src}, 32'd0);
    check("arst_flush_d", {31'b0, flush_d}, 32'd0);
    check("arst_flush_e", {31'b0, flush_e}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_target", pc_target, 32'h0);
    check("arst_count", {16'b0, taken_count}, 32'd0);
    #1 rst = 1'b0;
    idle();
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("post_rst_flush_e", {31'b0, flush_e}, 32'd0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0,
           3'($urandom_range(0, 7)), a, b, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
